// File: rtl/sign_magnitude_alu.sv
// Registered sign-magnitude add/subtract unit with an internal accumulator.
// Valid/ready on both sides, one output register with pass-through ready.
// Overflow either wraps or saturates the magnitude, depending on SATURATE.
module sign_magnitude_alu #(
  parameter int N        = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [1:0]   i_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_data,
  output logic         o_overflow,
  output logic [N-1:0] o_acc,
  output logic         o_acc_ovf
);

  localparam int M = N - 1;

  typedef enum logic [1:0] {
    OP_ADD     = 2'd0,
    OP_SUB     = 2'd1,
    OP_ACC_ADD = 2'd2,
    OP_LOAD    = 2'd3
  } op_e;

  logic         valid_q, valid_d;
  logic [N-1:0] data_q, data_d;
  logic         ovf_q, ovf_d;
  logic [N-1:0] acc_q, acc_d;
  logic         acc_ovf_q, acc_ovf_d;

  op_e          op;
  logic         accept;
  logic [M-1:0] mag_a, mag_y, res_mag;
  logic         sign_a, sign_y, raw_sign_y, res_sign, res_ovf;
  logic [N-1:0] sum_full;
  logic [N-1:0] result;

  // Ready is held low during reset and otherwise opens whenever the output slot frees up.
  assign o_ready = i_rst_n && (!valid_q || i_ready);
  assign accept  = i_valid && o_ready;

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_overflow = ovf_q;
  assign o_acc      = acc_q;
  assign o_acc_ovf  = acc_ovf_q;

  // Datapath: pick the second operand, add or subtract magnitudes, apply overflow policy and normalise -0.
  always_comb begin
    op         = op_e'(i_op);
    mag_a      = i_a[M-1:0];
    sign_a     = i_a[N-1] && (mag_a != '0);
    mag_y      = i_b[M-1:0];
    raw_sign_y = i_b[N-1];
    res_mag    = '0;
    res_sign   = 1'b0;
    res_ovf    = 1'b0;

    case (op)
      OP_SUB: begin
        mag_y      = i_b[M-1:0];
        raw_sign_y = !i_b[N-1];
      end
      OP_ACC_ADD: begin
        mag_y      = acc_q[M-1:0];
        raw_sign_y = acc_q[N-1];
      end
      default: begin
        mag_y      = i_b[M-1:0];
        raw_sign_y = i_b[N-1];
      end
    endcase
    sign_y   = raw_sign_y && (mag_y != '0);
    sum_full = {1'b0, mag_a} + {1'b0, mag_y};

    if (sign_a == sign_y) begin
      res_ovf  = sum_full[N-1];
      res_mag  = (res_ovf && SATURATE) ? {M{1'b1}} : sum_full[M-1:0];
      res_sign = sign_a;
    end else if (mag_a >= mag_y) begin
      res_mag  = mag_a - mag_y;
      res_sign = sign_a;
    end else begin
      res_mag  = mag_y - mag_a;
      res_sign = sign_y;
    end

    if (op == OP_LOAD) begin
      res_mag  = mag_a;
      res_sign = sign_a;
      res_ovf  = 1'b0;
    end

    result = {res_sign && (res_mag != '0), res_mag};
  end

  // Next-state: capture on accept, drop valid on drain, otherwise hold everything.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    ovf_d     = ovf_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = result;
      ovf_d   = res_ovf;
      if (op == OP_ACC_ADD) begin
        acc_d     = result;
        acc_ovf_d = acc_ovf_q || res_ovf;
      end else if (op == OP_LOAD) begin
        acc_d     = result;
        acc_ovf_d = 1'b0;
      end
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers, cleared immediately by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
    end
  end

endmodule

// File: tb/tb_sign_magnitude_alu.sv
// Directed bench for sign_magnitude_alu: a wrapping and a saturating instance share all inputs.
module tb_sign_magnitude_alu;

  logic       clk;
  logic       rstN;
  logic       inValid;
  logic       outReady;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       consReady;

  logic       outValid, outValidSat;
  logic       readySat;
  logic [7:0] data, dataSat;
  logic       ovf, ovfSat;
  logic [7:0] acc, accSat;
  logic       accOvf, accOvfSat;

  int checks = 0;
  int errors = 0;

  sign_magnitude_alu #(.N(8), .SATURATE(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_valid(inValid), .o_ready(outReady),
    .i_op(op), .i_a(a), .i_b(b), .o_valid(outValid), .i_ready(consReady),
    .o_data(data), .o_overflow(ovf), .o_acc(acc), .o_acc_ovf(accOvf)
  );

  sign_magnitude_alu #(.N(8), .SATURATE(1'b1)) dutSat (
    .i_clk(clk), .i_rst_n(rstN), .i_valid(inValid), .o_ready(readySat),
    .i_op(op), .i_a(a), .i_b(b), .o_valid(outValidSat), .i_ready(consReady),
    .o_data(dataSat), .o_overflow(ovfSat), .o_acc(accSat), .o_acc_ovf(accOvfSat)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one transaction, let it be taken at the next edge, then sample 1 ns later.
  task automatic drive(input logic [1:0] tOp, input logic [7:0] tA, input logic [7:0] tB);
    op      = tOp;
    a       = tA;
    b       = tB;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  // Outputs must be zero while reset is held, and ready must come up after release.
  task automatic test_reset();
    checks++;
    if ({outValid, data, ovf, acc, accOvf, outReady} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got v=%b d=%h o=%b acc=%h ao=%b rdy=%b want all 0",
               outValid, data, ovf, acc, accOvf, outReady);
    end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checks++;
    if (outReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready got %b want 1", outReady);
    end
  endtask

  // Directed add/subtract vectors: mixed signs, -0 handling and overflow in both policies.
  task automatic test_arith();
    logic [1:0] vOp  [10] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0};
    logic [7:0] vA   [10] = '{8'h05, 8'h03, 8'h80, 8'h64, 8'h05, 8'h02, 8'h80, 8'h85, 8'hC0, 8'hFF};
    logic [7:0] vB   [10] = '{8'h83, 8'h03, 8'h80, 8'h32, 8'h07, 8'h85, 8'h85, 8'h05, 8'hC0, 8'h7F};
    logic [7:0] vW   [10] = '{8'h02, 8'h00, 8'h00, 8'h16, 8'h82, 8'h07, 8'h85, 8'h8A, 8'h00, 8'h00};
    logic [7:0] vS   [10] = '{8'h02, 8'h00, 8'h00, 8'h7F, 8'h82, 8'h07, 8'h85, 8'h8A, 8'hFF, 8'h00};
    logic       vOvf [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(vOp[i], vA[i], vB[i]);
      checks++;
      if (outValid !== 1'b1 || data !== vW[i] || ovf !== vOvf[i]) begin
        errors++;
        $display("[TB] FAIL arith_wrap[%0d] got v=%b d=%h o=%b want v=1 d=%h o=%b",
                 i, outValid, data, ovf, vW[i], vOvf[i]);
      end
      checks++;
      if (dataSat !== vS[i] || ovfSat !== vOvf[i]) begin
        errors++;
        $display("[TB] FAIL arith_sat[%0d] got d=%h o=%b want d=%h o=%b",
                 i, dataSat, ovfSat, vS[i], vOvf[i]);
      end
    end
  endtask

  // Back-to-back accumulator chain, sticky overflow and its clearing by a load.
  task automatic test_accumulator();
    logic [1:0] vOp  [8] = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1};
    logic [7:0] vA   [8] = '{8'h8A, 8'h04, 8'h06, 8'h7F, 8'h7F, 8'h01, 8'h10, 8'h01};
    logic [7:0] vB   [8] = '{8'h55, 8'hAA, 8'h33, 8'h00, 8'h00, 8'h02, 8'hEE, 8'h01};
    logic [7:0] vW   [8] = '{8'h8A, 8'h86, 8'h00, 8'h7F, 8'h7E, 8'h03, 8'h10, 8'h00};
    logic [7:0] vAcc [8] = '{8'h8A, 8'h86, 8'h00, 8'h7F, 8'h7E, 8'h7E, 8'h10, 8'h10};
    logic [7:0] vAccS[8] = '{8'h8A, 8'h86, 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h10, 8'h10};
    logic       vOvf [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       vAo  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    consReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(vOp[i], vA[i], vB[i]);
      checks++;
      if (outValid !== 1'b1 || data !== vW[i] || ovf !== vOvf[i] || acc !== vAcc[i] || accOvf !== vAo[i]) begin
        errors++;
        $display("[TB] FAIL acc_wrap[%0d] got v=%b d=%h o=%b acc=%h ao=%b want d=%h o=%b acc=%h ao=%b",
                 i, outValid, data, ovf, acc, accOvf, vW[i], vOvf[i], vAcc[i], vAo[i]);
      end
      checks++;
      if (accSat !== vAccS[i] || accOvfSat !== vAo[i]) begin
        errors++;
        $display("[TB] FAIL acc_sat[%0d] got acc=%h ao=%b want acc=%h ao=%b",
                 i, accSat, accOvfSat, vAccS[i], vAo[i]);
      end
    end
  endtask

  // Stall with a pending input for three cycles, then release and drain.
  task automatic test_backpressure();
    consReady = 1'b1;
    drive(2'd3, 8'h05, 8'h00);
    drive(2'd2, 8'h03, 8'h00);
    consReady = 1'b0;
    op        = 2'd2;
    a         = 8'h01;
    b         = 8'h00;
    inValid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outReady !== 1'b0 || outValid !== 1'b1 || data !== 8'h08 || acc !== 8'h08) begin
        errors++;
        $display("[TB] FAIL stall[%0d] got rdy=%b v=%b d=%h acc=%h want rdy=0 v=1 d=08 acc=08",
                 i, outReady, outValid, data, acc);
      end
      @(posedge clk);
      #1;
    end
    consReady = 1'b1;
    #1;
    checks++;
    if (outReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release_ready got %b want 1", outReady);
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checks++;
    if (outValid !== 1'b1 || data !== 8'h09 || acc !== 8'h09) begin
      errors++;
      $display("[TB] FAIL stall_accept got v=%b d=%h acc=%h want v=1 d=09 acc=09", outValid, data, acc);
    end
    a = 8'h7F;
    op = 2'd3;
    @(posedge clk);
    #1;
    checks++;
    if (outValid !== 1'b0 || data !== 8'h09 || acc !== 8'h09) begin
      errors++;
      $display("[TB] FAIL drain got v=%b d=%h acc=%h want v=0 d=09 acc=09", outValid, data, acc);
    end
  endtask

  // Reset pulled mid-cycle during a stall must clear everything before the next edge.
  task automatic test_async_reset();
    consReady = 1'b1;
    drive(2'd2, 8'h02, 8'h00);
    consReady = 1'b0;
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if ({outValid, data, ovf, acc, accOvf, outReady} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL async_reset got v=%b d=%h o=%b acc=%h ao=%b rdy=%b want all 0",
               outValid, data, ovf, acc, accOvf, outReady);
    end
    #2;
    rstN = 1'b1;
    #1;
    checks++;
    if (outReady !== 1'b1 || outValid !== 1'b0 || acc !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_release got rdy=%b v=%b acc=%h want rdy=1 v=0 acc=00",
               outReady, outValid, acc);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    rstN      = 1'b0;
    inValid   = 1'b0;
    consReady = 1'b1;
    op        = 2'd0;
    a         = 8'h00;
    b         = 8'h00;
    #2;
    test_reset();
    @(posedge clk);
    #1;
    test_arith();
    test_accumulator();
    test_backpressure();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sign_magnitude_alu.md
# sign_magnitude_alu

Registered, handshaked sign-magnitude arithmetic unit. It is the successor to the team's combinational sign-magnitude adder. It adds width parametrisation, subtraction, an internal accumulator, overflow detection with a selectable wrap or saturate policy, and negative-zero normalisation. It sits between an operand producer and a result consumer, with valid/ready on both sides.

## Interface
- N, default 8: total word width including the sign bit in MSB. Must be at least 3. Magnitude is N-1 bits.
- SATURATE, default 0: overflow policy. 0 keeps the low N-1 magnitude bits (wrap). 1 clamps the magnitude to 2^(N-1)-1.

Ports (name, direction, width, meaning):
- i_clk  in  1  sole clock; all state updates on its rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_valid  in  1  operand transaction valid.
- o_ready  out  1  unit can accept an operand transaction.
- i_op  in  2  opcode:
  - 0: A+B
  - 1: A−B
  - 2: ACC+A, writes ACC
  - 3: load ACC=A, clears sticky overflow
- i_a  in  N  operand A, sign-magnitude.
- i_b  in  N  operand B, sign-magnitude. Ignored for ops 2 and 3.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_data  out  N  result, sign-magnitude.
- o_overflow  out  1  overflow flag for the transaction held in o_data.
- o_acc  out  N  current accumulator value.
- o_acc_ovf  out  1  sticky flag: some op 2 overflowed since the last op 3 or reset.

## Operation
- Accept: a transaction is accepted when i_valid && o_ready at a rising edge.
- Operand normalisation:
  - For op 1, the sign of B is inverted before addition.
  - For op 2, the second operand is ACC.
  - An input magnitude of 0 is treated as +0 regardless of its sign bit.
- Same signs:
  - sum = magA + magB, computed N bits wide.
  - Result sign = the common sign.
  - Overflow = bit N-1 of sum.
- Different signs:
  - The larger magnitude minus the smaller magnitude.
  - Result sign = sign of the larger-magnitude operand.
  - Overflow is never raised.
- Equal magnitudes with opposite signs: the result is +0.
- Overflow policy:
  - SATURATE=0: magnitude = sum[N-2:0].
  - SATURATE=1: magnitude = all ones.
  - o_overflow is 1 in both modes.
- Output normalisation: any result with zero magnitude is emitted with sign 0. o_data and o_acc never hold −0.
- Op 3:
  - ACC = normalised A; o_data = normalised A; o_overflow = 0; o_acc_ovf cleared.
- Op 2:
  - ACC = result; o_data = result; o_acc_ovf |= overflow.
- Ops 0 and 1 leave ACC and o_acc_ovf unchanged.

## Timing
- Reset (asynchronous, takes effect immediately on i_rst_n low, independent of i_clk):
  - o_valid=0, o_data=0, o_overflow=0, o_acc=0, o_acc_ovf=0.
  - While held in reset, o_ready=0.
  - After release, o_ready=1.
- Latency is 1 cycle. A transaction accepted at edge k appears on o_data/o_overflow with o_valid=1 after edge k.
- o_ready = !o_valid || i_ready, i.e. a single output register with pass-through ready. There is no combinational path from i_valid to o_valid.
- Full throughput: with i_ready held high, one transaction is accepted per cycle.
- Back-to-back op 2 or op 3 transactions see the ACC written by the previous accepted transaction, with no bubbles.
- Stall: while o_valid && !i_ready:
  - o_data, o_overflow, o_acc and o_acc_ovf hold stable.
  - No transaction is accepted.
  - ACC is not modified.
- Drain: when o_valid && i_ready && !(i_valid && o_ready), o_valid falls at the next edge. o_data keeps its last value.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one and o_valid stays 1.
- i_op, i_a and i_b are sampled only on accept. Their value at any other time has no effect.
- Reset asserted mid-stall discards the held result and clears ACC.

## Test plan
- Mixed signs, N=8, op 0, i_a=0x05 (+5), i_b=0x83 (−3) -> one cycle later o_data=0x02, o_overflow=0, o_valid=1.
- Zero normalisation, N=8:
  - op 1, i_a=0x03, i_b=0x03 -> o_data=0x00, not 0x80.
  - op 0, i_a=0x80, i_b=0x80 -> o_data=0x00.
- Overflow, op 0, i_a=0x64 (+100), i_b=0x32 (+50):
  - SATURATE=0 -> o_data=0x16, o_overflow=1.
  - SATURATE=1 -> o_data=0x7F, o_overflow=1.
- Accumulator, back-to-back with i_ready=1:
  - op 3 with A=0x8A -> o_acc=0x8A.
  - Then op 2 with A=0x04 -> o_data=o_acc=0x86.
  - Then op 2 with A=0x06 -> o_data=o_acc=0x00.
  - Then op 2 with A=0x7F, twice -> second result has overflow, o_acc_ovf=1.
  - Then op 3 -> o_acc_ovf=0.
- Backpressure:
  - Accept op 2, then hold i_ready=0 for 3 cycles with i_valid=1 -> o_ready=0, o_data and o_acc stable, no accept.
  - Raise i_ready -> the pending input is accepted at the same edge.
- Asynchronous reset: pull i_rst_n low mid-cycle while o_valid=1 and ACC≠0 -> all outputs 0 immediately, before the next i_clk edge. o_ready=1 after release.
